// File: rtl/top_level.sv
// Pattern-count engine: scans a 32-byte message for a 5-bit pattern and writes in-byte, per-byte and stream counts.
// Optional STATUS_BYTE_EN adds a final 0xA5 status byte at OUT_ADDR+3.

module dat_mem #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [7:0]    i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [7:0]    o_rdata
);
   logic [7:0] core [0:DEPTH-1];

   // Contents are deliberately not reset so preloaded data survives reset.
   always_ff @(posedge clk) begin
      if (i_we) core[i_waddr] <= i_wdata;
   end

   assign o_rdata = core[i_raddr];
endmodule

module top_level #(
   parameter int unsigned MEM_DEPTH = 256,
   parameter int unsigned MSG_BYTES = 32,
   parameter int unsigned PAT_ADDR  = 32,
   parameter int unsigned OUT_ADDR  = 33
) (
   input  logic clk,
   input  logic reset,
   output logic done
);
   localparam int unsigned AW = $clog2(MEM_DEPTH);
   localparam int unsigned KW = $clog2(MSG_BYTES);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SCAN, S_WR_B, S_WR_O, S_WR_S, S_WR_F, S_DONE
   } state_t;

   state_t          r_state;
   logic            r_done;
   logic [4:0]      r_pat;
   logic [7:0]      r_prev;
   logic [KW-1:0]   r_k;
   logic [7:0]      r_ctb;
   logic [7:0]      r_cto;
   logic [7:0]      r_cts;

   logic [AW-1:0]   w_raddr;
   logic [7:0]      w_rdata;
   logic            w_we;
   logic [AW-1:0]   w_waddr;
   logic [7:0]      w_wdata;
   logic [2:0]      w_m;
   logic [2:0]      w_x;
   logic [11:0]     w_cat;

   assign w_raddr = (r_state == S_LOAD) ? AW'(PAT_ADDR) : AW'(r_k);

   dat_mem #(.DEPTH(MEM_DEPTH), .AW(AW)) datMem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   // In-byte matches (w_m) and matches straddling the previous byte (w_x, MSB in prev).
   assign w_cat = {r_prev[3:0], w_rdata};
   always_comb begin
      w_m = 3'd0;
      w_x = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (w_rdata[7-i -: 5] == r_pat) w_m = w_m + 3'd1;
         if ((r_k != '0) && (w_cat[11-i -: 5] == r_pat)) w_x = w_x + 3'd1;
      end
   end

   // Result write-back port.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = '0;
      w_wdata = 8'd0;
      case (r_state)
         S_WR_B: begin w_we = 1'b1; w_waddr = AW'(OUT_ADDR);     w_wdata = r_ctb; end
         S_WR_O: begin w_we = 1'b1; w_waddr = AW'(OUT_ADDR + 1); w_wdata = r_cto; end
         S_WR_S: begin w_we = 1'b1; w_waddr = AW'(OUT_ADDR + 2); w_wdata = r_cts; end
`ifdef STATUS_BYTE_EN
         S_WR_F: begin w_we = 1'b1; w_waddr = AW'(OUT_ADDR + 3); w_wdata = 8'hA5; end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
         r_pat   <= 5'd0;
         r_prev  <= 8'd0;
         r_k     <= '0;
         r_ctb   <= 8'd0;
         r_cto   <= 8'd0;
         r_cts   <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: r_state <= S_LOAD;
            S_LOAD: begin
               r_pat   <= w_rdata[7:3];
               r_k     <= '0;
               r_state <= S_SCAN;
            end
            S_SCAN: begin
               r_ctb  <= r_ctb + 8'(w_m);
               if (w_m != 3'd0) r_cto <= r_cto + 8'd1;
               r_cts  <= r_cts + 8'(w_m) + 8'(w_x);
               r_prev <= w_rdata;
               r_k    <= r_k + KW'(1);
               if (r_k == KW'(MSG_BYTES - 1)) r_state <= S_WR_B;
            end
            S_WR_B: r_state <= S_WR_O;
            S_WR_O: r_state <= S_WR_S;
`ifdef STATUS_BYTE_EN
            S_WR_S: r_state <= S_WR_F;
            S_WR_F: begin
               r_state <= S_DONE;
               r_done  <= 1'b1;
            end
`else
            S_WR_S: begin
               r_state <= S_DONE;
               r_done  <= 1'b1;
            end
`endif
            S_DONE: r_state <= S_DONE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign done = r_done;
endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level: hand-computed count vectors, a stream-level reference model, and mid-run reset.
module tb_top_level;
   logic clk;
   logic reset;
   logic done;

   int checks = 0;
   int errors = 0;

`ifdef STATUS_BYTE_EN
   localparam int LAT = 38;
`else
   localparam int LAT = 37;
`endif

   logic [7:0] msg [32];
   logic [4:0] pat;
   int         e_ctb, e_cto, e_cts;
   int         cyc;

   top_level dut (.clk(clk), .reset(reset), .done(done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [7:0] status);
      for (int i = 0; i < 32; i++) dut.datMem.core[i] = msg[i];
      dut.datMem.core[32] = {pat, 3'b101};
      dut.datMem.core[33] = 8'hEE;
      dut.datMem.core[34] = 8'hEE;
      dut.datMem.core[35] = 8'hEE;
      dut.datMem.core[36] = status;
   endtask

   // Release reset at a negedge and count rising edges until done is seen.
   task automatic release_and_wait(output int n_cyc);
      @(negedge clk);
      reset = 1'b1;
      n_cyc = 0;
      for (int n = 1; n <= 80; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            n_cyc = n;
            break;
         end
      end
   endtask

   task automatic enter_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic check_results(input string tag, input int ctb, input int cto, input int cts);
      check({tag, "_ctb"}, 32'(dut.datMem.core[33]), 32'(ctb));
      check({tag, "_cto"}, 32'(dut.datMem.core[34]), 32'(cto));
      check({tag, "_cts"}, 32'(dut.datMem.core[35]), 32'(cts));
   endtask

   // Reference: flatten into a 256-bit MSB-first stream and classify every 5-bit window.
   task automatic model(output int ctb, output int cto, output int cts);
      logic [0:255] st;
      logic [4:0]   w;
      logic [31:0]  hit;
      ctb = 0; cto = 0; cts = 0; hit = '0;
      for (int k = 0; k < 32; k++)
         for (int j = 0; j < 8; j++) st[k*8 + j] = msg[k][7-j];
      for (int q = 0; q <= 251; q++) begin
         for (int b = 0; b < 5; b++) w[4-b] = st[q+b];
         if (w == pat) begin
            cts++;
            if ((q / 8) == ((q + 4) / 8)) begin
               ctb++;
               hit[q/8] = 1'b1;
            end
         end
      end
      for (int k = 0; k < 32; k++) if (hit[k]) cto++;
   endtask

   initial begin
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_done", 32'(done), 32'd0);

      // All-zero message, all-zero pattern: every window matches.
      pat = 5'b00000;
      for (int i = 0; i < 32; i++) msg[i] = 8'h00;
      preload(8'h3C);
      release_and_wait(cyc);
      check("t1_latency", 32'(cyc), 32'(LAT));
      check_results("t1", 128, 32, 252);
`ifdef STATUS_BYTE_EN
      check("t1_status", 32'(dut.datMem.core[36]), 32'hA5);
`else
      check("t1_status", 32'(dut.datMem.core[36]), 32'h3C);
`endif

      // Alternating bits: two in-byte and two crossing hits per byte.
      enter_reset();
      check("t2_reset_done", 32'(done), 32'd0);
      pat = 5'b10101;
      for (int i = 0; i < 32; i++) msg[i] = 8'h55;
      preload(8'h3C);
      release_and_wait(cyc);
      check("t2_latency", 32'(cyc), 32'(LAT));
      check_results("t2", 64, 32, 126);

      // No match anywhere; message and pattern bytes untouched.
      enter_reset();
      pat = 5'b11111;
      for (int i = 0; i < 32; i++) msg[i] = 8'h00;
      preload(8'h3C);
      release_and_wait(cyc);
      check("t3_latency", 32'(cyc), 32'(LAT));
      check_results("t3", 0, 0, 0);
      check("t3_msg0", 32'(dut.datMem.core[0]), 32'h00);
      check("t3_msg31", 32'(dut.datMem.core[31]), 32'h00);
      check("t3_pat", 32'(dut.datMem.core[32]), 32'hFD);

      // Single match straddling bytes 0 and 1.
      enter_reset();
      pat = 5'b11111;
      for (int i = 0; i < 32; i++) msg[i] = 8'h00;
      msg[0] = 8'h07;
      msg[1] = 8'hC0;
      preload(8'h3C);
      release_and_wait(cyc);
      check_results("t4", 0, 0, 1);
      check("t4_msg1", 32'(dut.datMem.core[1]), 32'hC0);

      // Random message against the stream model.
      enter_reset();
      pat = 5'($urandom_range(0, 31));
      for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
      msg[5] = {pat, 3'b010};
      msg[9] = {3'b000, pat};
      preload(8'h3C);
      model(e_ctb, e_cto, e_cts);
      release_and_wait(cyc);
      check("t5_latency", 32'(cyc), 32'(LAT));
      check_results("t5", e_ctb, e_cto, e_cts);

      // Asynchronous reset while done is high drops it immediately.
      #2;
      reset = 1'b0;
      #1;
      check("t5_done_drop", 32'(done), 32'd0);

      // Abort in mid-scan, then rerun from scratch.
      @(negedge clk);
      reset = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("t6_abort_done", 32'(done), 32'd0);
      check("t6_keep_ctb", 32'(dut.datMem.core[33]), 32'(e_ctb));
      dut.datMem.core[33] = 8'hEE;
      dut.datMem.core[34] = 8'hEE;
      dut.datMem.core[35] = 8'hEE;
      repeat (2) @(posedge clk);
      release_and_wait(cyc);
      check("t6_latency", 32'(cyc), 32'(LAT));
      check_results("t6", e_ctb, e_cto, e_cts);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/top_level.md
Name: top_level

Overview:
- Self-contained pattern-count engine, the top of the program-3 build. Owns a 256x8 data memory.
- On reset release it reads a 5-bit pattern and a 32-byte message from memory. It computes three occurrence counts, writes them back to memory and raises done.
- Memory instance is named datMem, with storage array core. The bench preloads and inspects it hierarchically (datMem.core[i]).

Parameters:
- MEM_DEPTH, 256: data memory words (8-bit each)
- MSG_BYTES, 32: message length in bytes, addresses 0..MSG_BYTES-1
- PAT_ADDR, 32: address of pattern byte; pattern = core[PAT_ADDR][7:3]
- OUT_ADDR, 33: base of results; core[33]=ctb, core[34]=cto, core[35]=cts

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- done  output  1  high when results are written; held until next reset

Behaviour:
- Memory datMem: 256x8 array core. Combinational read, synchronous write on the clk rising edge.
- Memory contents are NOT cleared by reset, so backdoor preloads survive.
- Reset low (asynchronous): FSM returns to IDLE, done=0, all counters, pattern register and previous-byte register clear to 0.
- FSM states:
  - IDLE: first clk edge with reset high -> LOAD.
  - LOAD: latch pat = core[32][7:3] -> SCAN, with index k=0.
  - SCAN: one byte per cycle, reading core[k] for k=0..31; after k=31 -> WR_B.
  - WR_B: write ctb to core[33] -> WR_O.
  - WR_O: write cto to core[34] -> WR_S.
  - WR_S: write cts to core[35] -> DONE.
  - DONE: done=1; remain until reset.
- Latency: 1+1+32+3 = 37 cycles from the first edge with reset high until done is registered high.
- Per byte b=core[k] in SCAN:
  - m = count of i in 0..3 with b[i+4:i]==pat.
  - ctb += m.
  - cto += 1 if m>0.
  - cts += m, plus (k>0) the count of crossing windows of {prev[3:0], b} starting in prev bits 3..0. There are 4 crossing windows; each is 5 bits whose MSB lies in prev.
  - prev <= b.
- Bit stream for cts is byte 0 first, MSB first. There are 252 windows total (128 in-byte + 124 crossing).
- Maximum values: ctb 128, cto 32, cts 252. All counters are 8-bit and cannot overflow.
- Only core[33..35] are written (plus core[36] under the option below); message and pattern bytes stay unchanged.
- Reset asserted mid-run aborts immediately: done=0, no further writes. Already-written result bytes keep their values. Release restarts from IDLE and recomputes from current memory contents.
- pat bits: core[32][2:0] are ignored.

Optional Feature:
- Macro STATUS_BYTE_EN.
- Defined: extra state WR_F after WR_S writes 8'hA5 to core[36]; done rises one cycle later (38-cycle latency).
- Undefined: core[36] is never written; latency 37.

Test Plan:
- pat=00000, all 32 bytes 0x00 -> core[33]=128, core[34]=32, core[35]=252, done high 37 cycles after reset release.
- pat=10101, all bytes 0x55 -> core[33]=64, core[34]=32, core[35]=126.
- pat=11111, all bytes 0x00 -> core[33]=0, core[34]=0, core[35]=0; message bytes unchanged.
- pat=11111, core[0]=0x07, core[1]=0xC0, rest 0x00 -> core[33]=0, core[34]=0, core[35]=1 (crossing-only match).
- Random message/pattern (compare against software model of the three counts) -> exact match. Then assert reset at cycle 20 of a run: done drops at once; on release, identical results after 37 cycles.
- STATUS_BYTE_EN defined -> core[36]=0xA5, done at cycle 38; undefined -> core[36] retains preload value.
